// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the UART baud tick generator.
// Provides the config FSM states, legal oversample rates and 100 MHz divisor presets.
package uart_baud_pkg;

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_t;

    localparam int OS_8  = 8;
    localparam int OS_16 = 16;

    localparam longint SYS_CLK_HZ = 100_000_000;

    // Returns the rounded divisor as {int, frac} fixed point with frac_bits fraction bits.
    function automatic logic [31:0] baud_div(input longint sys_clk, input longint baud,
                                             input longint os, input longint frac_bits);
        longint den;
        den = baud * os;
        return 32'(((sys_clk << frac_bits) + den / 2) / den);
    endfunction

    localparam logic [31:0] DIV_4800   = baud_div(SYS_CLK_HZ, 4800,   OS_16, 4);
    localparam logic [31:0] DIV_9600   = baud_div(SYS_CLK_HZ, 9600,   OS_16, 4);
    localparam logic [31:0] DIV_19200  = baud_div(SYS_CLK_HZ, 19200,  OS_16, 4);
    localparam logic [31:0] DIV_38400  = baud_div(SYS_CLK_HZ, 38400,  OS_16, 4);
    localparam logic [31:0] DIV_57600  = baud_div(SYS_CLK_HZ, 57600,  OS_16, 4);
    localparam logic [31:0] DIV_115200 = baud_div(SYS_CLK_HZ, 115200, OS_16, 4);

endpackage

// File: rtl/uart_baud_tick_gen_prescaler.sv
// Fractional prescaler producing the oversample tick (accumulator only with UART_BAUD_FRAC_EN).
// Latency: tick registered one cycle after the strobe that ends each interval.
// Backpressure: none; clear and enable-low restart the interval immediately.
module uart_frac_prescaler #(
    parameter int DIV_INT_W = 16,
    parameter int FRAC_BITS = 4
) (
    input  logic                 core_clk,
    input  logic                 arst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_INT_W-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    output logic                 os_strobe,
    output logic                 os_tick
);

    localparam int CW = DIV_INT_W + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] interval;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_BITS-1:0] acc;
    logic                 carry_q;
    logic [FRAC_BITS:0]   acc_sum;

    assign acc_sum  = {1'b0, acc} + {1'b0, div_frac};
    assign interval = {1'b0, div_int} + CW'(carry_q);

    // carry_q stretches the interval that follows the tick producing it.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (!enable || clear) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (os_strobe) begin
            {carry_q, acc} <= acc_sum;
        end
    end
`else
    logic [FRAC_BITS-1:0] frac_unused;

    assign frac_unused = div_frac;
    assign interval    = {1'b0, div_int};
`endif

    assign os_strobe = enable && !clear && (cnt == interval);

    // The tick edge itself is the first cycle of the next interval, hence reload to 1.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else if (!enable || clear) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else begin
            os_tick <= os_strobe;
            cnt     <= os_strobe ? CW'(1) : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// UART baud tick generator: oversample, TX bit and RX mid-bit ticks (fractional divisor with UART_BAUD_FRAC_EN).
// Latency: ticks registered; a new divisor applies in the TX tick cycle, at most one bit period plus one cycle.
// Backpressure: Cfg_Ready_Out low while a divisor is pending; further offers wait.
module uart_baud_tick_gen
    import uart_baud_pkg::*;
#(
    parameter int OVERSAMPLE       = OS_16,
    parameter int DIV_INT_W        = 16,
    parameter int FRAC_BITS        = 4,
    parameter int DEFAULT_DIV_INT  = int'(DIV_115200 >> 4),
    parameter int DEFAULT_DIV_FRAC = int'(DIV_115200 & 32'hF)
) (
    input  logic                 Clk_In,
    input  logic                 Reset_N_In,
    input  logic                 Enable_In,
    input  logic                 Cfg_Valid_In,
    output logic                 Cfg_Ready_Out,
    input  logic [DIV_INT_W-1:0] Cfg_Div_Int_In,
    input  logic [FRAC_BITS-1:0] Cfg_Div_Frac_In,
    input  logic                 Rx_Restart_In,
    output logic                 Os_Tick_Out,
    output logic                 Tx_Tick_Out,
    output logic                 Rx_Sample_Tick_Out
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] RX_MID_PREV = CNT_W'(OVERSAMPLE / 2 - 1);

    if (OVERSAMPLE != OS_8 && OVERSAMPLE != OS_16) begin : g_bad_oversample
        $error("OVERSAMPLE must be 8 or 16");
    end

    function automatic logic [DIV_INT_W-1:0] clamp_div(input logic [DIV_INT_W-1:0] d);
        return (d < DIV_INT_W'(2)) ? DIV_INT_W'(2) : d;
    endfunction

    localparam logic [DIV_INT_W-1:0] RST_DIV_INT  = clamp_div(DIV_INT_W'(DEFAULT_DIV_INT));
    localparam logic [FRAC_BITS-1:0] RST_DIV_FRAC = FRAC_BITS'(DEFAULT_DIV_FRAC);

    cfg_state_t           state_q, state_d;
    logic                 capture, apply;
    logic [DIV_INT_W-1:0] shadow_int_q, div_int_q;
    logic [FRAC_BITS-1:0] shadow_frac_q, div_frac_q;
    logic                 os_strobe, os_tick;
    logic [CNT_W-1:0]     tx_cnt_q, rx_cnt_q;
    logic                 tx_tick_q, rx_tick_q;

    // Applying on the registered TX tick keeps every divisor change on a bit boundary.
    always_comb begin
        state_d       = state_q;
        Cfg_Ready_Out = 1'b0;
        capture       = 1'b0;
        apply         = 1'b0;
        case (state_q)
            CFG_IDLE: begin
                Cfg_Ready_Out = 1'b1;
                if (Cfg_Valid_In) begin
                    capture = 1'b1;
                    state_d = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (tx_tick_q || !Enable_In) begin
                    apply   = 1'b1;
                    state_d = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q       <= CFG_IDLE;
            shadow_int_q  <= '0;
            shadow_frac_q <= '0;
            div_int_q     <= RST_DIV_INT;
            div_frac_q    <= RST_DIV_FRAC;
        end else begin
            state_q <= state_d;
            if (capture) begin
                shadow_int_q  <= Cfg_Div_Int_In;
                shadow_frac_q <= Cfg_Div_Frac_In;
            end
            if (apply) begin
                div_int_q  <= clamp_div(shadow_int_q);
                div_frac_q <= shadow_frac_q;
            end
        end
    end

    uart_frac_prescaler #(
        .DIV_INT_W (DIV_INT_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_prescaler (
        .core_clk  (Clk_In),
        .arst_n    (Reset_N_In),
        .enable    (Enable_In),
        .clear     (apply),
        .div_int   (div_int_q),
        .div_frac  (div_frac_q),
        .os_strobe (os_strobe),
        .os_tick   (os_tick)
    );

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            tx_cnt_q  <= '0;
            tx_tick_q <= 1'b0;
        end else if (!Enable_In) begin
            tx_cnt_q  <= '0;
            tx_tick_q <= 1'b0;
        end else begin
            tx_tick_q <= os_strobe && (tx_cnt_q == TX_LAST);
            if (os_strobe) begin
                tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
        end
    end

    // A restart swallows a coincident oversample tick so the next sample lands mid-bit.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            rx_cnt_q  <= '0;
            rx_tick_q <= 1'b0;
        end else if (!Enable_In || Rx_Restart_In) begin
            rx_cnt_q  <= '0;
            rx_tick_q <= 1'b0;
        end else begin
            rx_tick_q <= os_strobe && (rx_cnt_q == RX_MID_PREV);
            if (os_strobe) begin
                rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
        end
    end

    assign Os_Tick_Out        = os_tick;
    assign Tx_Tick_Out        = tx_tick_q;
    assign Rx_Sample_Tick_Out = rx_tick_q;

endmodule
